// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU scheduler: op codes, FSM states and
// the per-op execution latency.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_XOR     = 4'd1,
    OP_OR      = 4'd2,
    OP_AND     = 4'd3,
    OP_NOR     = 4'd4,
    OP_SLL     = 4'd5,
    OP_SRL     = 4'd6,
    OP_SLT     = 4'd7,
    OP_ADD     = 4'd8,
    OP_ADDU    = 4'd9,
    OP_SUB     = 4'd10,
    OP_SUBU    = 4'd11,
    OP_MULT    = 4'd12,
    OP_DIV     = 4'd13,
    OP_SRA     = 4'd14,
    OP_ILLEGAL = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  // Number of cycles an op occupies EXEC (1..16). The raw 4-bit code is taken
  // so callers can pass request pins directly, including the illegal code.
  function automatic logic [4:0] op_latency(input logic [3:0] op,
                                            input int       mul_cycles,
                                            input int       div_cycles);
    logic [4:0] lat;
    lat = 5'd1;
    if (op == OP_MULT) begin
      lat = 5'(mul_cycles);
    end else if (op == OP_DIV) begin
      lat = 5'(div_cycles);
    end
    return lat;
  endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the priority pointer; the pointer moves to the other requester whenever a
// grant is taken (accept strobe).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // prio1 = 1 means requester 1 wins the next tie
  logic prio1;

  // One-hot grant; ties resolved by the pointer
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio1 ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Point away from whoever was just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio1 <= 1'b0;
    end else if (accept) begin
      prio1 <= grant[0];
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters. Arbitrates
// round-robin, holds the ALU inputs for the op's latency, then registers the
// result until the consumer takes it.
//
// state | meaning
// IDLE  | ALU inputs parked at NOP/0, requests may be granted
// EXEC  | latched op/operands drive the ALU, latency down-counter running
// RESP  | result registered and presented, waiting for resp_ready
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_zero,
  output logic            resp_negative,
  output logic            resp_err,
  output logic [XLEN-1:0] alu_input1,
  output logic [XLEN-1:0] alu_input2,
  output logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_negative
);

  sched_state_t    state;
  logic [3:0]      cnt;
  logic            id_r;
  logic [3:0]      op_r;
  logic [XLEN-1:0] in1_r;
  logic [XLEN-1:0] in2_r;

  logic [1:0]      req_vec;
  logic [1:0]      grant;
  logic            accept;

  logic [3:0]      sel_op;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic            sel_id;
  logic [4:0]      sel_lat;
  logic [3:0]      sel_cnt;

  logic [XLEN-1:0] res_data;
  logic            res_zero;
  logic            res_negative;
  logic            res_err;

  // Requests only compete while idle; outside IDLE both readys stay low
  assign req_vec = (state == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .grant  (grant)
  );

  // A grant is only issued to a valid requester, so grant == handshake
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;

  // Payload mux for the granted requester and its latency preload
  always_comb begin
    sel_id  = grant[1];
    sel_op  = grant[1] ? req1_op : req0_op;
    sel_a   = grant[1] ? req1_a  : req0_a;
    sel_b   = grant[1] ? req1_b  : req0_b;
    sel_lat = op_latency(sel_op, MUL_CYCLES, DIV_CYCLES);
    sel_cnt = 4'(sel_lat - 5'd1);
  end

  // Result selection at terminal count; error cases override the ALU
  always_comb begin
    res_data     = alu_out;
    res_zero     = alu_zero;
    res_negative = alu_negative;
    res_err      = 1'b0;
    if (op_r == OP_ILLEGAL) begin
      res_data     = '0;
      res_zero     = 1'b1;
      res_negative = 1'b0;
      res_err      = 1'b1;
    end else if ((op_r == OP_DIV) && (in2_r == '0)) begin
      res_data     = '1;
      res_zero     = 1'b0;
      res_negative = 1'b1;
      res_err      = 1'b1;
    end
  end

  // The latched op/operands are cleared outside EXEC so they double as the
  // ALU drive registers: NOP/0 in IDLE and RESP without extra muxing.
  assign alu_operation = op_r;
  assign alu_input1    = in1_r;
  assign alu_input2    = in2_r;

  // Scheduler FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      id_r          <= 1'b0;
      op_r          <= '0;
      in1_r         <= '0;
      in2_r         <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_data     <= '0;
      resp_zero     <= 1'b0;
      resp_negative <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_r  <= sel_id;
            op_r  <= sel_op;
            in1_r <= sel_a;
            in2_r <= sel_b;
            cnt   <= sel_cnt;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            resp_valid    <= 1'b1;
            resp_id       <= id_r;
            resp_data     <= res_data;
            resp_zero     <= res_zero;
            resp_negative <= res_negative;
            resp_err      <= res_err;
            op_r          <= '0;
            in1_r         <= '0;
            in2_r         <= '0;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
